// File: rtl/dm_pkg.sv
// Shared types and helpers for the MonoCycle data memory.
package dm_pkg;

    localparam int unsigned DM_WORD_BYTES = 4;
    localparam int unsigned DM_DATA_W     = 32;

    // funct3 encodings of the RV32I load/store width field
    typedef enum logic [2:0] {
        DM_B  = 3'b000,
        DM_H  = 3'b001,
        DM_W  = 3'b010,
        DM_BU = 3'b100,
        DM_HU = 3'b101
    } dm_ctrl_e;

    // Store payload after lane alignment: byte enables plus lane-replicated data
    typedef struct packed {
        logic [DM_WORD_BYTES-1:0] be;
        logic [DM_DATA_W-1:0]     data;
    } dm_wr_s;

    // True for the five load widths the memory understands
    function automatic logic is_legal_ctrl(input logic [2:0] ctrl);
        logic legal;
        case (ctrl)
            DM_B, DM_H, DM_W, DM_BU, DM_HU: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering between a 32-bit memory word and the core's load/store data.
// Load path extracts and extends; store path produces byte enables and shifted data.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [DM_DATA_W-1:0] rd_word,
    input  logic [1:0]           addr_lo,
    input  logic [2:0]           ctrl,
    input  logic [DM_DATA_W-1:0] wr_data,
    output logic [DM_DATA_W-1:0] ld_data_c,
    output dm_wr_s               st_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed byte and halfword from the raw word
    always_comb begin
        byte_sel = 8'(rd_word >> {addr_lo, 3'b000});
        half_sel = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
    end

    // Extend the selected lane according to the load width
    always_comb begin
        ld_data_c = '0;
        case (ctrl)
            DM_B:    ld_data_c = {{24{byte_sel[7]}}, byte_sel};
            DM_BU:   ld_data_c = {24'h000000, byte_sel};
            DM_H:    ld_data_c = {{16{half_sel[15]}}, half_sel};
            DM_HU:   ld_data_c = {16'h0000, half_sel};
            DM_W:    ld_data_c = rd_word;
            default: ld_data_c = '0;
        endcase
    end

    // Build byte enables and replicate store data onto every lane
    always_comb begin
        st_c = '0;
        case (ctrl)
            DM_B: begin
                st_c.be   = 4'(4'b0001 << addr_lo);
                st_c.data = {4{wr_data[7:0]}};
            end
            DM_H: begin
                st_c.be   = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_c.data = {2{wr_data[15:0]}};
            end
            DM_W: begin
                st_c.be   = 4'b1111;
                st_c.data = wr_data;
            end
            default: st_c = '0;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Single-cycle data memory: combinational byte/half/word loads, synchronous
// byte-enabled stores, little-endian, addresses wrap modulo DEPTH_WORDS*4.
// Optional misaligned-access trap enabled by defining DM_MISALIGN_TRAP_EN.
module data_memory
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          Address,
    input  logic [31:0]          DataWr,
    input  logic                 DMWr,
    input  logic                 DMRd,
    input  logic [2:0]           DMCtrl,
    output logic [31:0]          DataRd,
    output logic                 MisalignErr,
    output logic [31:0]          ErrAddr
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [AW-1:0]          word_idx;
    logic [DM_DATA_W-1:0]   mem_q [DEPTH_WORDS];
    logic [DM_DATA_W-1:0]   mem_d [DEPTH_WORDS];
    logic [DM_DATA_W-1:0]   rd_word;
    logic [DM_DATA_W-1:0]   ld_data_c;
    dm_wr_s                 st_c;
    logic                   ld_misalign_c;
    logic                   st_misalign_c;
    logic                   unused_addr_hi;

    assign word_idx       = Address[AW+1:2];
    assign rd_word        = mem_q[word_idx];
    assign unused_addr_hi = ^Address[31:AW+2];

    dm_lane_align u_lane_align (
        .rd_word   (rd_word),
        .addr_lo   (Address[1:0]),
        .ctrl      (DMCtrl),
        .wr_data   (DataWr),
        .ld_data_c (ld_data_c),
        .st_c      (st_c)
    );

`ifdef DM_MISALIGN_TRAP_EN
    logic        err_q, err_d;
    logic [31:0] err_addr_q, err_addr_d;

    // Flag halfword accesses on odd addresses and word accesses off a word boundary
    always_comb begin
        ld_misalign_c = 1'b0;
        st_misalign_c = 1'b0;
        case (DMCtrl)
            DM_H: begin
                ld_misalign_c = DMRd & Address[0];
                st_misalign_c = DMWr & Address[0];
            end
            DM_HU: ld_misalign_c = DMRd & Address[0];
            DM_W: begin
                ld_misalign_c = DMRd & (|Address[1:0]);
                st_misalign_c = DMWr & (|Address[1:0]);
            end
            default: ;
        endcase
    end

    // Sticky flag; only the first faulting address is captured
    always_comb begin
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (ld_misalign_c || st_misalign_c) begin
            err_d = 1'b1;
            if (!err_q) err_addr_d = Address;
        end
    end

    // Error register update
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign MisalignErr = err_q;
    assign ErrAddr     = err_addr_q;
`else
    assign ld_misalign_c = 1'b0;
    assign st_misalign_c = 1'b0;
    assign MisalignErr   = 1'b0;
    assign ErrAddr       = '0;
`endif

    // Load result is qualified by the read enable, a legal width and alignment
    always_comb begin
        DataRd = '0;
        if (DMRd && is_legal_ctrl(DMCtrl) && !ld_misalign_c) DataRd = ld_data_c;
    end

    // Merge enabled store lanes into the addressed word
    always_comb begin
        mem_d = mem_q;
        if (DMWr && !st_misalign_c) begin
            for (int unsigned l = 0; l < DM_WORD_BYTES; l++) begin
                if (st_c.be[l]) mem_d[word_idx][8*l +: 8] = st_c.data[8*l +: 8];
            end
        end
    end

    // Array register; reset clears every word and overrides any store
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: byte-array reference model checked every cycle,
// plus directed vectors with literal expectations. Honours DM_MISALIGN_TRAP_EN.
module tb_data_memory;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned NBYTES = DEPTH * 4;
`ifdef DM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata;
    logic        wr, rd;
    logic [2:0]  ctrl;
    logic [31:0] data_rd;
    logic        merr;
    logic [31:0] eaddr;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    logic [7:0]  mm [NBYTES];
    logic        m_err;
    logic [31:0] m_eaddr;

    always #5 clk = ~clk;

    data_memory #(.DEPTH_WORDS(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .Address     (addr),
        .DataWr      (wdata),
        .DMWr        (wr),
        .DMRd        (rd),
        .DMCtrl      (ctrl),
        .DataRd      (data_rd),
        .MisalignErr (merr),
        .ErrAddr     (eaddr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Misalignment as seen by the architecture: halfwords need even, words need 4-byte alignment
    function automatic bit is_mis(input logic [31:0] a, input logic [2:0] c, input bit store);
        if (!TRAP) return 1'b0;
        if (c == 3'b001 || (!store && c == 3'b101)) return a[0];
        if (c == 3'b010) return (a[1:0] != 2'b00);
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] c, input logic r);
        int unsigned b;
        int unsigned base;
        logic [7:0]  v;
        logic [15:0] h;
        b = a % NBYTES;
        if (!r || is_mis(a, c, 1'b0)) return 32'h0;
        case (c)
            3'b000: begin v = mm[b]; return {{24{v[7]}}, v}; end
            3'b100: begin v = mm[b]; return {24'h0, v}; end
            3'b001, 3'b101: begin
                base = b & ~32'd1;
                h = {mm[base+1], mm[base]};
                return (c == 3'b001) ? {{16{h[15]}}, h} : {16'h0, h};
            end
            3'b010: begin
                base = b & ~32'd3;
                return {mm[base+3], mm[base+2], mm[base+1], mm[base]};
            end
            default: return 32'h0;
        endcase
    endfunction

    // Reference model state update
    always @(posedge clk) begin
        int unsigned b;
        bit ld_mis, st_mis;
        if (rst) begin
            for (int i = 0; i < NBYTES; i++) mm[i] = 8'h00;
            m_err   = 1'b0;
            m_eaddr = 32'h0;
        end else begin
            b      = addr % NBYTES;
            ld_mis = rd && is_mis(addr, ctrl, 1'b0);
            st_mis = wr && is_mis(addr, ctrl, 1'b1);
            if (wr && !st_mis) begin
                case (ctrl)
                    3'b000: mm[b] = wdata[7:0];
                    3'b001: begin
                        mm[b & ~32'd1]       = wdata[7:0];
                        mm[(b & ~32'd1) + 1] = wdata[15:8];
                    end
                    3'b010: for (int k = 0; k < 4; k++) mm[(b & ~32'd3) + k] = wdata[8*k +: 8];
                    default: ;
                endcase
            end
            if (ld_mis || st_mis) begin
                if (!m_err) m_eaddr = addr;
                m_err = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_DataRd", data_rd, m_load(addr, ctrl, rd));
            check("cyc_MisalignErr", 32'(merr), 32'(m_err));
            check("cyc_ErrAddr", eaddr, m_eaddr);
        end
    end

    task automatic apply(input logic r, input logic [31:0] a, input logic [31:0] d,
                         input logic w, input logic rr, input logic [2:0] c);
        @(posedge clk);
        #1;
        rst = r; addr = a; wdata = d; wr = w; rd = rr; ctrl = c;
        cmp_en = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [2:0] codes [7];
        codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b111};
        rst = 1'b1; addr = '0; wdata = '0; wr = 1'b0; rd = 1'b0; ctrl = 3'b010;
        repeat (2) @(posedge clk);

        // Post-reset reads
        apply(0, 32'h000, 0, 0, 1, 3'b010);
        check("rst_lw_000", data_rd, 32'h0);
        check("rst_merr", 32'(merr), 32'h0);
        apply(0, 32'h3FC, 0, 0, 1, 3'b010);
        check("rst_lw_3fc", data_rd, 32'h0);

        // Word store then narrow loads
        apply(0, 32'h80, 32'h8899AABB, 1, 0, 3'b010);
        apply(0, 32'h80, 0, 0, 1, 3'b000);
        check("lb_80", data_rd, 32'hFFFFFFBB);
        apply(0, 32'h83, 0, 0, 1, 3'b100);
        check("lbu_83", data_rd, 32'h00000088);
        apply(0, 32'h82, 0, 0, 1, 3'b001);
        check("lh_82", data_rd, 32'hFFFF8899);
        apply(0, 32'h80, 0, 0, 1, 3'b101);
        check("lhu_80", data_rd, 32'h0000AABB);

        // Byte store merges into one lane
        apply(0, 32'h81, 32'h11223344, 1, 0, 3'b000);
        apply(0, 32'h80, 0, 0, 1, 3'b010);
        check("sb_merge", data_rd, 32'h889944BB);

        // Non-store width code and read gating
        apply(0, 32'h80, 32'hFFFFFFFF, 1, 0, 3'b100);
        apply(0, 32'h80, 0, 0, 1, 3'b010);
        check("bu_nowrite", data_rd, 32'h889944BB);
        apply(0, 32'h80, 0, 0, 0, 3'b010);
        check("rd_off", data_rd, 32'h0);
        apply(0, 32'h80, 0, 0, 1, 3'b011);
        check("illegal_ctrl", data_rd, 32'h0);

        // Read-during-write sees old data, then new
        apply(0, 32'h10, 32'h12345678, 1, 0, 3'b010);
        apply(0, 32'h10, 32'hCAFEF00D, 1, 1, 3'b010);
        check("rdw_old", data_rd, 32'h12345678);
        apply(0, 32'h10, 0, 0, 1, 3'b010);
        check("rdw_new", data_rd, 32'hCAFEF00D);

        // Address wrap
        apply(0, 32'h400, 32'hA5A5A5A5, 1, 0, 3'b010);
        apply(0, 32'h000, 0, 0, 1, 3'b010);
        check("wrap", data_rd, 32'hA5A5A5A5);

`ifdef DM_MISALIGN_TRAP_EN
        apply(0, 32'h22, 32'h01020304, 1, 0, 3'b010);
        apply(0, 32'h20, 0, 0, 1, 3'b010);
        check("mis_sw_nowrite", data_rd, 32'h0);
        check("mis_flag", 32'(merr), 32'h1);
        check("mis_addr", eaddr, 32'h22);
        apply(0, 32'h45, 0, 0, 1, 3'b001);
        check("mis_lh_zero", data_rd, 32'h0);
        apply(0, 32'h20, 0, 0, 1, 3'b010);
        check("mis_addr_kept", eaddr, 32'h22);
        apply(1, 32'h0, 0, 0, 0, 3'b010);
        apply(0, 32'h0, 0, 0, 1, 3'b010);
        check("mis_rst_flag", 32'(merr), 32'h0);
        check("mis_rst_addr", eaddr, 32'h0);
`else
        apply(0, 32'h22, 32'h01020304, 1, 0, 3'b010);
        apply(0, 32'h20, 0, 0, 1, 3'b010);
        check("nomis_sw", data_rd, 32'h01020304);
        check("nomis_flag", 32'(merr), 32'h0);
        apply(0, 32'h23, 0, 0, 1, 3'b101);
        check("nomis_lhu", data_rd, 32'h00000102);
`endif

        // Reset beats a simultaneous store
        apply(0, 32'h30, 32'hDEADBEEF, 1, 0, 3'b010);
        apply(0, 32'h30, 0, 0, 1, 3'b010);
        check("pre_rst_30", data_rd, 32'hDEADBEEF);
        apply(1, 32'h30, 32'h11111111, 1, 0, 3'b010);
        apply(0, 32'h30, 0, 0, 1, 3'b010);
        check("rst_over_sw", data_rd, 32'h0);

        // Mixed traffic checked by the model
        for (int i = 0; i < 80; i++) begin
            apply(0, 32'($urandom_range(0, 32'h7FF)), $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), codes[$urandom_range(0, 6)]);
        end

        @(posedge clk);
        #1;
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
